// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction fetch queue.
package fetch_pkg;

  localparam int INSTR_W_DEF = 32;
  localparam int DEPTH_DEF   = 512;
  localparam int ADDR_W_DEF  = $clog2(DEPTH_DEF);

  typedef enum logic [1:0] {
    ST_PROG  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  // One prefetched word together with the word address it came from.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy output; push and pop may share a
// cycle at any occupancy.
module fetch_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_q.sv
// Instruction fetch stage: PC, programmable instruction memory and prefetch FIFO.
// Optional FETCH_STATS_EN adds fetch_cnt / flush_cnt statistics outputs.
module instr_fetch_q
  import fetch_pkg::*;
#(
  parameter int INSTR_W    = INSTR_W_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int RESET_PC   = 0,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               program_en,
  input  logic [ADDR_W-1:0]  program_addr,
  input  logic [INSTR_W-1:0] program_instr,
  input  logic               redirect_en,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               stall_en,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output fetch_state_e       state
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int ENTRY_W = INSTR_W + ADDR_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  fetch_state_e       state_next;
  logic               rd_inflight;
  logic [INSTR_W-1:0] rd_data;
  logic [ADDR_W-1:0]  rd_pc;
  logic               flush;
  logic               issue;
  logic               push;
  logic               pop;
  logic               fifo_empty;
  logic [CNT_W-1:0]   occ;
  logic [ENTRY_W-1:0] head;
  logic [INSTR_W-1:0] last_instr;
  logic [ADDR_W-1:0]  last_pc;

  // Handshake: the head word transfers on a rising edge where instr_valid=1 and
  // stall_en=0; a flush in that same cycle cancels the transfer.
  assign instr_valid = !fifo_empty;
  assign push        = rd_inflight && !flush;
  assign pop         = instr_valid && !stall_en && !flush;

  always_comb begin
    state_next = state;
    pc_next    = pc;
    flush      = 1'b0;
    issue      = 1'b0;
    if (program_en) begin
      state_next = ST_PROG;
      pc_next    = ADDR_W'(RESET_PC);
      flush      = 1'b1;
    end else if (redirect_en) begin
      state_next = ST_REDIR;
      pc_next    = redirect_pc;
      flush      = 1'b1;
    end else begin
      case (state)
        ST_PROG:  state_next = ST_RUN;
        ST_REDIR: state_next = ST_RUN;
        ST_RUN:   state_next = ST_RUN;
        default:  state_next = ST_RUN;
      endcase
      // Counting in-flight reads against capacity means a push never finds the FIFO full.
      issue = (int'(occ) + int'(rd_inflight)) < FIFO_DEPTH;
      if (issue) pc_next = pc + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      pc          <= ADDR_W'(RESET_PC);
      rd_inflight <= 1'b0;
      rd_pc       <= '0;
      last_instr  <= '0;
      last_pc     <= '0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      rd_inflight <= issue;
      if (issue) rd_pc <= pc;
      if (instr_valid) {last_instr, last_pc} <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (program_en) mem[program_addr] <= program_instr;
    if (issue)      rd_data <= mem[pc];
  end

  fetch_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push),
    .push_data({rd_data, rd_pc}),
    .pop      (pop),
    .head     (head),
    .count    (occ),
    .empty    (fifo_empty)
  );

  // Outputs hold the last delivered word while the FIFO is empty.
  assign instr    = instr_valid ? head[ENTRY_W-1:ADDR_W] : last_instr;
  assign instr_pc = instr_valid ? head[ADDR_W-1:0]       : last_pc;

`ifdef FETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pop) fetch_cnt <= fetch_cnt + 32'd1;
      if (!program_en && redirect_en && ((occ != '0) || rd_inflight))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_q.sv
// Directed bench for instr_fetch_q: programming, streaming, stall, redirect,
// reprogramming, async reset, and PC wrap on a 16-word instance.
module tb_instr_fetch_q;
  import fetch_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic        program_en, redirect_en, stall_en;
  logic [8:0]  program_addr, redirect_pc;
  logic [31:0] program_instr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [8:0]  instr_pc;
  fetch_state_e state;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_cnt, fetch_cnt_s;
  logic [15:0] flush_cnt, flush_cnt_s;
`endif

  instr_fetch_q dut (
    .clk(clk), .rst(rst),
    .program_en(program_en), .program_addr(program_addr), .program_instr(program_instr),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .stall_en(stall_en),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .state(state)
`ifdef FETCH_STATS_EN
    , .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // ---------------- DUT with DEPTH = 16 ----------------
  logic        program_en_s, redirect_en_s, stall_en_s;
  logic [3:0]  program_addr_s, redirect_pc_s;
  logic [31:0] program_instr_s;
  logic        instr_valid_s;
  logic [31:0] instr_s;
  logic [3:0]  instr_pc_s;
  fetch_state_e state_s;

  instr_fetch_q #(.DEPTH(16)) dut16 (
    .clk(clk), .rst(rst),
    .program_en(program_en_s), .program_addr(program_addr_s), .program_instr(program_instr_s),
    .redirect_en(redirect_en_s), .redirect_pc(redirect_pc_s), .stall_en(stall_en_s),
    .instr_valid(instr_valid_s), .instr(instr_s), .instr_pc(instr_pc_s), .state(state_s)
`ifdef FETCH_STATS_EN
    , .fetch_cnt(fetch_cnt_s), .flush_cnt(flush_cnt_s)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [40:0] exp_q[$];
  logic [31:0] model_mem [512];
  logic [31:0] model16 [16];
  logic [31:0] w [14];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      int p;
      p = (start + i) % 512;
      exp_q.push_back({model_mem[p], 9'(p)});
    end
  endtask

  // Consume n words (stall_en must be 0) and compare each against exp_q in order.
  task automatic drain_check(input int n, input string tag);
    int got;
    int budget;
    fetch_entry_t e;
    got = 0;
    budget = 0;
    while (got < n && budget < n + 20) begin
      if (instr_valid) begin
        e = exp_q.pop_front();
        check({tag, "_instr"}, instr, e.instr);
        check({tag, "_pc"}, instr_pc, e.pc);
        got++;
      end
      step();
      budget++;
    end
    if (got < n) begin
      n_checks++;
      n_err++;
      $display("FAIL %s_timeout: got %0d words expected %0d", tag, got, n);
    end
    exp_q.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    w = '{32'h00a000b7, 32'h003000d7, 32'h00108133, 32'h40208233, 32'h0020f2b3,
          32'h0020e333, 32'h0020c3b3, 32'h00209433, 32'h0020d4b3, 32'h4020d533,
          32'h00402583, 32'h00b02223, 32'hfe209ee3, 32'h0000001f};
    rst = 1'b1;
    program_en = 0; program_addr = '0; program_instr = '0;
    redirect_en = 0; redirect_pc = '0; stall_en = 0;
    program_en_s = 0; program_addr_s = '0; program_instr_s = '0;
    redirect_en_s = 0; redirect_pc_s = '0; stall_en_s = 0;
    #12;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_pc", instr_pc, 0);
    check("rst_state", state, ST_RUN);

    // Program 14 words, then release and measure latency.
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      program_en = 1; program_addr = 9'(i); program_instr = w[i];
      model_mem[i] = w[i];
      step();
    end
    check("prog_state", state, ST_PROG);
    program_en = 0;
    check("prog_lat0", instr_valid, 0);
    step();
    check("prog_lat1", instr_valid, 0);
    step();
    check("prog_first_valid", instr_valid, 1);
    push_exp(0, 6);
    drain_check(6, "stream");

    // Stall: FIFO saturates at 4, head stays put; release flows without gaps.
    stall_en = 1;
    for (int i = 0; i < 10; i++) step();
    check("stall_occ", dut.u_fifo.count, 4);
    check("stall_valid", instr_valid, 1);
    check("stall_instr", instr, w[6]);
    check("stall_pc", instr_pc, 6);
    stall_en = 0;
    push_exp(6, 8);
    drain_check(8, "release");

    // Redirect to 9 while full.
    stall_en = 1;
    for (int i = 0; i < 6; i++) step();
    check("full_before_redir", dut.u_fifo.count, 4);
    redirect_en = 1; redirect_pc = 9'd9;
    step();
    redirect_en = 0; stall_en = 0;
    check("redir_lat0", instr_valid, 0);
    check("redir_state", state, ST_REDIR);
    step();
    check("redir_lat1", instr_valid, 0);
    check("redir_state_run", state, ST_RUN);
    step();
    check("redir_first_valid", instr_valid, 1);
    push_exp(9, 5);
    drain_check(5, "redir");
`ifdef FETCH_STATS_EN
    check("flush_cnt", flush_cnt, 1);
    check("fetch_cnt", fetch_cnt, 19);
`endif

    // Reprogram mid-stream: restart at 0 with the patched word at 3.
    program_en = 1; program_addr = 9'd3; program_instr = 32'hdeadbeef;
    model_mem[3] = 32'hdeadbeef;
    step();
    program_en = 0;
    check("reprog_flush", instr_valid, 0);
    check("reprog_state", state, ST_PROG);
    step();
    step();
    push_exp(0, 5);
    drain_check(5, "reprog");
`ifdef FETCH_STATS_EN
    check("flush_cnt_prog", flush_cnt, 1);
`endif

    // Asynchronous reset mid-stall.
    stall_en = 1;
    for (int i = 0; i < 4; i++) step();
    check("prerst_valid", instr_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", instr_valid, 0);
    check("async_rst_instr", instr, 0);
    check("async_rst_pc", instr_pc, 0);
    check("async_rst_state", state, ST_RUN);
`ifdef FETCH_STATS_EN
    check("async_rst_fetch_cnt", fetch_cnt, 0);
    check("async_rst_flush_cnt", flush_cnt, 0);
`endif
    #1;
    rst = 1'b0;
    stall_en = 0;
    push_exp(0, 4);
    drain_check(4, "post_rst");

    // DEPTH = 16 instance: redirect to 15 wraps to 0.
    for (int i = 0; i < 16; i++) begin
      model16[i] = 32'hc0de0000 | 32'(i);
      program_en_s = 1; program_addr_s = 4'(i); program_instr_s = model16[i];
      step();
    end
    program_en_s = 0;
    step();
    step();
    check("d16_first_valid", instr_valid_s, 1);
    redirect_en_s = 1; redirect_pc_s = 4'd15;
    step();
    redirect_en_s = 0;
    check("d16_redir_lat0", instr_valid_s, 0);
    step();
    step();
    check("d16_valid", instr_valid_s, 1);
    check("d16_pc15", instr_pc_s, 15);
    check("d16_instr15", instr_s, model16[15]);
    step();
    check("d16_pc0", instr_pc_s, 0);
    check("d16_instr0", instr_s, model16[0]);
    step();
    check("d16_pc1", instr_pc_s, 1);
    check("d16_instr1", instr_s, model16[1]);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
